rgb_pwm: RTL and testbench

- Three-channel PWM output stage sitting directly downstream of the HSV fade generator.
- Consumes per-channel duty values (0..PWM_INTERVAL) and drives the RGB LED pins.
- Duty values are latched into shadow registers only at period boundaries, so a mid-period change never produces a glitch pulse.
- Supports a clean start and a drained stop: an enable drop always completes the current period before the outputs go off.

---
 rtl/rgb_pwm_pkg.sv | 20 ++
 rtl/rgb_pwm_channel.sv | 79 +++++++
 rtl/rgb_pwm.sv | 170 +++++++++++++++++
 tb/tb_rgb_pwm.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pwm_pkg.sv
// -----------------------------------------------------------------------------
// rgb_pwm_pkg
// Shared types and helpers for the three-channel RGB PWM output stage.
//   rgb_pwm_state_e : run-control FSM state (IDLE / RUN / DRAIN), 2-bit encoding
//   pwm_width()     : width of the counter and duty inputs for a given period
// -----------------------------------------------------------------------------
package rgb_pwm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rgb_pwm_state_e;

  // Counter / duty width for a period of 'interval' clocks.
  function automatic int pwm_width(input int interval);
    return $clog2(interval);
  endfunction

endpackage

// File: rtl/rgb_pwm_channel.sv
// -----------------------------------------------------------------------------
// pwm_channel
// One PWM channel: duty shadow register with clamp, phase-offset compare and a
// registered LED pin with selectable polarity.
//
// Ports
//   clk, reset  : system clock, synchronous active-high reset
//   load        : latch the (clamped) duty input into the shadow register
//   active      : period counter is running (RUN or DRAIN); pin is off when low
//   phase       : compare offset in clocks, 0 <= phase < PWM_INTERVAL
//   count       : shared period counter, 0..PWM_INTERVAL-1
//   pwm_value   : requested duty in clocks; >= PWM_INTERVAL means always on
//   led         : registered pin, low-when-on if ACTIVE_LOW
// -----------------------------------------------------------------------------
module pwm_channel
  import rgb_pwm_pkg::*;
#(
  parameter int PWM_INTERVAL = 1200,
  parameter bit ACTIVE_LOW   = 1'b1,
  localparam int W           = pwm_width(PWM_INTERVAL)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         active,
  input  logic [W-1:0] phase,
  input  logic [W-1:0] count,
  input  logic [W-1:0] pwm_value,
  output logic         led
);

  // One extra bit so the period length itself is representable in compares.
  localparam logic [W:0] INTERVAL_X = (W+1)'(PWM_INTERVAL);
  localparam logic       LED_ON     = ACTIVE_LOW ? 1'b0 : 1'b1;
  localparam logic       LED_OFF    = ~LED_ON;

  logic [W-1:0] shadow;
  logic [W-1:0] clamped;
  logic [W:0]   phased_sum;
  logic [W-1:0] cmp_count;
  logic         pin_on;

  // Clamp at the load so an out-of-range request is never stored. When the
  // period is a power of two the inputs cannot reach it and the clamp never
  // fires.
  always_comb begin
    clamped = pwm_value;
    if ({1'b0, pwm_value} >= INTERVAL_X) begin
      clamped = INTERVAL_X[W-1:0];
    end
  end

  // (count + phase) mod PWM_INTERVAL by a single conditional subtract; both
  // operands are below the period so one subtract is always enough.
  always_comb begin
    phased_sum = {1'b0, count} + {1'b0, phase};
    cmp_count  = phased_sum[W-1:0];
    if (phased_sum >= INTERVAL_X) begin
      cmp_count = W'(phased_sum - INTERVAL_X);
    end
  end

  // Compare uses the shadow value held before this edge, so a load and the
  // last compare of the old period happen on the same edge without mixing.
  assign pin_on = active && (cmp_count < shadow);

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= '0;
      led    <= LED_OFF;
    end else begin
      if (load) begin
        shadow <= clamped;
      end
      led <= pin_on ? LED_ON : LED_OFF;
    end
  end

endmodule

// File: rtl/rgb_pwm.sv
// -----------------------------------------------------------------------------
// rgb_pwm
// Three-channel PWM output stage for an RGB LED. Duty values are sampled into
// per-channel shadow registers only at period boundaries (and on start), so a
// duty change mid-period never produces a glitch pulse. Dropping enable lets
// the current period finish (DRAIN) before the pins go off.
//
// Configuration
//   RGB_PWM_PHASE_STAGGER_EN : when defined, green compares against
//     (count + PWM_INTERVAL/3) mod PWM_INTERVAL and blue against
//     (count + 2*PWM_INTERVAL/3) mod PWM_INTERVAL so the rising edges of the
//     three channels are spread across the period. Undefined: all channels
//     compare against the raw count.
//
// Ports
//   clk, reset            : system clock, synchronous active-high reset
//   enable                : level-sensitive run request (no handshake; RUN is
//                           entered on the first edge it is seen high, and a
//                           drop is honoured at the end of the current period)
//   pwm_value_r/_g/_b     : duty in clocks, >= PWM_INTERVAL means 100 %
//   led_r/_g/_b           : registered LED pins, polarity per ACTIVE_LOW
//   period_start          : high while count == 0 in RUN or DRAIN
//   busy                  : high in RUN or DRAIN
//   state_dbg             : current run-control FSM state
// -----------------------------------------------------------------------------
module rgb_pwm
  import rgb_pwm_pkg::*;
#(
  parameter int PWM_INTERVAL = 1200,
  parameter bit ACTIVE_LOW   = 1'b1,
  localparam int W           = pwm_width(PWM_INTERVAL)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  input  logic [W-1:0]   pwm_value_r,
  input  logic [W-1:0]   pwm_value_g,
  input  logic [W-1:0]   pwm_value_b,
  output logic           led_r,
  output logic           led_g,
  output logic           led_b,
  output logic           period_start,
  output logic           busy,
  output rgb_pwm_state_e state_dbg
);

  localparam logic [W-1:0] LAST_COUNT = W'(PWM_INTERVAL - 1);

`ifdef RGB_PWM_PHASE_STAGGER_EN
  localparam logic [W-1:0] PHASE_R = '0;
  localparam logic [W-1:0] PHASE_G = W'(PWM_INTERVAL / 3);
  localparam logic [W-1:0] PHASE_B = W'((2 * PWM_INTERVAL) / 3);
`else
  localparam logic [W-1:0] PHASE_R = '0;
  localparam logic [W-1:0] PHASE_G = '0;
  localparam logic [W-1:0] PHASE_B = '0;
`endif

  rgb_pwm_state_e state;
  rgb_pwm_state_e state_next;
  logic [W-1:0]   count;
  logic [W-1:0]   count_next;
  logic           at_end;
  logic           load;
  logic           active;

  assign at_end = (count == LAST_COUNT);
  assign active = (state == RUN) || (state == DRAIN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Shadows reload only when the next period is a RUN period: on start and at
  // a wrap that stays in (or returns to) RUN. A period entered from DRAIN
  // mid-way keeps the shadows it started with until the next wrap.
  always_comb begin
    state_next = state;
    count_next = count;
    load       = 1'b0;
    unique case (state)
      IDLE: begin
        count_next = '0;
        if (enable) begin
          state_next = RUN;
          load       = 1'b1;
        end
      end
      RUN: begin
        if (at_end) begin
          count_next = '0;
          if (enable) begin
            load = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          count_next = count + W'(1);
          if (!enable) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (at_end) begin
          count_next = '0;
          if (enable) begin
            state_next = RUN;
            load       = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          count_next = count + W'(1);
          if (enable) begin
            state_next = RUN;
          end
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  assign busy         = active;
  assign period_start = active && (count == '0);
  assign state_dbg    = state;

  pwm_channel #(.PWM_INTERVAL(PWM_INTERVAL), .ACTIVE_LOW(ACTIVE_LOW)) u_chan_r (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .active    (active),
    .phase     (PHASE_R),
    .count     (count),
    .pwm_value (pwm_value_r),
    .led       (led_r)
  );

  pwm_channel #(.PWM_INTERVAL(PWM_INTERVAL), .ACTIVE_LOW(ACTIVE_LOW)) u_chan_g (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .active    (active),
    .phase     (PHASE_G),
    .count     (count),
    .pwm_value (pwm_value_g),
    .led       (led_g)
  );

  pwm_channel #(.PWM_INTERVAL(PWM_INTERVAL), .ACTIVE_LOW(ACTIVE_LOW)) u_chan_b (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .active    (active),
    .phase     (PHASE_B),
    .count     (count),
    .pwm_value (pwm_value_b),
    .led       (led_b)
  );

endmodule

// File: tb/tb_rgb_pwm.sv
// -----------------------------------------------------------------------------
// tb_rgb_pwm
// Directed bench for rgb_pwm with PWM_INTERVAL=12, ACTIVE_LOW=1. Expected pin
// levels come from the duty in force for each period and the counter value of
// the previous cycle (one clock of pin latency). Honours
// RGB_PWM_PHASE_STAGGER_EN for the green/blue compare offsets.
// -----------------------------------------------------------------------------
module tb_rgb_pwm;
  import rgb_pwm_pkg::*;

  localparam int INTERVAL = 12;
  localparam int W        = 4;

`ifdef RGB_PWM_PHASE_STAGGER_EN
  localparam int PH_G = INTERVAL / 3;
  localparam int PH_B = (2 * INTERVAL) / 3;
`else
  localparam int PH_G = 0;
  localparam int PH_B = 0;
`endif

  logic           clk;
  logic           reset;
  logic           enable;
  logic [W-1:0]   pwm_value_r;
  logic [W-1:0]   pwm_value_g;
  logic [W-1:0]   pwm_value_b;
  logic           led_r;
  logic           led_g;
  logic           led_b;
  logic           period_start;
  logic           busy;
  rgb_pwm_state_e state_dbg;

  int    checks = 0;
  int    errors = 0;
  string section = "init";

  rgb_pwm #(.PWM_INTERVAL(INTERVAL), .ACTIVE_LOW(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .pwm_value_r  (pwm_value_r),
    .pwm_value_g  (pwm_value_g),
    .pwm_value_b  (pwm_value_b),
    .led_r        (led_r),
    .led_g        (led_g),
    .led_b        (led_b),
    .period_start (period_start),
    .busy         (busy),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %0d expected %0d", section, tag, got, exp);
    end
  endtask

  // Active-low pin level for a channel whose compare saw counter value p.
  function automatic logic pin_level(input int p, input int duty, input int ph);
    return (((p + ph) % INTERVAL) < duty) ? 1'b0 : 1'b1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Advance from observed count 'from' to observed count 'to' (12 = wrap to 0)
  // and check every cycle. Pins reflect the previous count with the given duties.
  task automatic run_span(input int from, input int to, input int dr, input int dg,
                          input int db, input rgb_pwm_state_e st);
    for (int i = from + 1; i <= to; i++) begin
      int p;
      tick;
      p = i - 1;
      check("led_r", 32'(led_r), 32'(pin_level(p, dr, 0)));
      check("led_g", 32'(led_g), 32'(pin_level(p, dg, PH_G)));
      check("led_b", 32'(led_b), 32'(pin_level(p, db, PH_B)));
      check("period_start", 32'(period_start), 32'((i % INTERVAL) == 0));
      check("busy", 32'(busy), 32'd1);
      check("state", 32'(state_dbg), 32'(st));
    end
  endtask

  task automatic check_idle_pins;
    check("led_r", 32'(led_r), 32'd1);
    check("led_g", 32'(led_g), 32'd1);
    check("led_b", 32'(led_b), 32'd1);
    check("period_start", 32'(period_start), 32'd0);
    check("busy", 32'(busy), 32'd0);
    check("state", 32'(state_dbg), 32'(IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset held with enable already high: reset must win.
    section     = "reset";
    reset       = 1'b1;
    enable      = 1'b1;
    pwm_value_r = 4'd4;
    pwm_value_g = 4'd0;
    pwm_value_b = 4'd12;
    tick;
    tick;
    tick;
    check_idle_pins;

    // First RUN cycle: count 0, pins still off (they follow one clock later).
    section = "start";
    reset   = 1'b0;
    tick;
    check("led_r", 32'(led_r), 32'd1);
    check("led_g", 32'(led_g), 32'd1);
    check("led_b", 32'(led_b), 32'd1);
    check("period_start", 32'(period_start), 32'd1);
    check("busy", 32'(busy), 32'd1);
    check("state", 32'(state_dbg), 32'(RUN));

    section = "steady";
    run_span(0, 12, 4, 0, 12, RUN);
    run_span(0, 12, 4, 0, 12, RUN);

    // Duty change at count 5 only shows up in the next period.
    section = "mid_change";
    run_span(0, 5, 4, 0, 12, RUN);
    pwm_value_r = 4'd9;
    run_span(5, 12, 4, 0, 12, RUN);
    run_span(0, 12, 9, 0, 12, RUN);

    // Out-of-range request is clamped to a full period.
    section = "clamp";
    pwm_value_r = 4'd15;
    run_span(0, 12, 9, 0, 12, RUN);
    run_span(0, 12, 12, 0, 12, RUN);

    // Enable drop at count 3: period completes with old duties, then IDLE.
    section = "drain";
    pwm_value_r = 4'd4;
    run_span(0, 12, 12, 0, 12, RUN);
    run_span(0, 3, 4, 0, 12, RUN);
    enable      = 1'b0;
    pwm_value_r = 4'd9;
    run_span(3, 11, 4, 0, 12, DRAIN);
    tick;
    check("led_r", 32'(led_r), 32'(pin_level(11, 4, 0)));
    check("led_g", 32'(led_g), 32'(pin_level(11, 0, PH_G)));
    check("led_b", 32'(led_b), 32'(pin_level(11, 12, PH_B)));
    check("period_start", 32'(period_start), 32'd0);
    check("busy", 32'(busy), 32'd0);
    check("state", 32'(state_dbg), 32'(IDLE));
    tick;
    check_idle_pins;

    // Restart, then re-raise enable at count 7 of a second drain: the count
    // continues and the new duty waits for the wrap.
    section = "redrain";
    enable  = 1'b1;
    tick;
    check("state", 32'(state_dbg), 32'(RUN));
    check("period_start", 32'(period_start), 32'd1);
    run_span(0, 12, 9, 0, 12, RUN);
    run_span(0, 3, 9, 0, 12, RUN);
    enable = 1'b0;
    run_span(3, 7, 9, 0, 12, DRAIN);
    enable      = 1'b1;
    pwm_value_r = 4'd4;
    run_span(7, 12, 9, 0, 12, RUN);
    run_span(0, 12, 4, 0, 12, RUN);

    // Reset mid-period forces the idle state on the next edge.
    section = "reset_mid";
    run_span(0, 6, 4, 0, 12, RUN);
    reset = 1'b1;
    tick;
    check_idle_pins;
    tick;
    check_idle_pins;
    reset = 1'b0;
    tick;
    check("state", 32'(state_dbg), 32'(RUN));
    check("period_start", 32'(period_start), 32'd1);
    check("led_r", 32'(led_r), 32'd1);
    run_span(0, 12, 4, 0, 12, RUN);

    // Equal duties: aligned edges by default, staggered with the option.
    section     = "equal";
    pwm_value_g = 4'd4;
    pwm_value_b = 4'd4;
    run_span(0, 12, 4, 0, 12, RUN);
    run_span(0, 12, 4, 4, 4, RUN);
    run_span(0, 12, 4, 4, 4, RUN);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
